// File: rtl/pong_pkg.sv
// Shared definitions for the pong game engine: FSM state encoding and
// ball direction constants.
package pong_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/pong_paddle.sv
// Clamped up/down paddle register. o_moving reports, before the clock edge,
// whether the enabled update will change the paddle row.
module pong_paddle #(
    parameter int Y_W      = 7,
    parameter int SCR_H    = 120,
    parameter int PAD_H    = 12,
    parameter int PAD_STEP = 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           i_en,
    input  logic           i_up,
    input  logic           i_down,
    output logic [Y_W-1:0] o_y,
    output logic           o_moving
);

    localparam logic [Y_W:0]   Y_MAX  = (Y_W+1)'(SCR_H - PAD_H);
    localparam logic [Y_W-1:0] Y_INIT = Y_W'((SCR_H - PAD_H) / 2);
    localparam logic [Y_W-1:0] STEP   = Y_W'(PAD_STEP);

    logic [Y_W-1:0] r_y;
    logic [Y_W-1:0] w_y_nxt;
    logic [Y_W:0]   w_sum;

    assign w_sum = {1'b0, r_y} + {1'b0, STEP};

    always_comb begin
        // NOTE: default assignment first so every path drives w_y_nxt and no latch is inferred.
        w_y_nxt = r_y;
        if (i_up && !i_down) begin
            w_y_nxt = (r_y < STEP) ? '0 : r_y - STEP;
        end else if (i_down && !i_up) begin
            w_y_nxt = (w_sum > Y_MAX) ? Y_MAX[Y_W-1:0] : w_sum[Y_W-1:0];
        end
    end

    // NOTE: non-blocking assignments for registered state so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_y <= Y_INIT;
        end else if (i_en) begin
            r_y <= w_y_nxt;
        end
    end

    assign o_y      = r_y;
    assign o_moving = i_en && (w_y_nxt != r_y);

endmodule

// File: rtl/pong_core.sv
// Pong game engine: ball, paddles, scores, serve timing and game over.
// Define PONG_SPEEDUP_EN to shorten the ball divisor after every 4 paddle hits.
module pong_core
    import pong_pkg::*;
#(
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int SCR_W       = 160,
    parameter int SCR_H       = 120,
    parameter int PAD_H       = 12,
    parameter int PAD_STEP    = 1,
    parameter int P1_X        = 2,
    parameter int P2_X        = 157,
    parameter int SCORE_W     = 4,
    parameter int WIN_SCORE   = 9,
    parameter int SERVE_TICKS = 30,
    parameter int BALL_DIV    = 4
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tick,
    input  logic               go,
    input  logic               p1_up,
    input  logic               p1_down,
    input  logic               p2_up,
    input  logic               p2_down,
    output logic [X_W-1:0]     ball_x,
    output logic [Y_W-1:0]     ball_y,
    output logic [Y_W-1:0]     pad1_y,
    output logic [Y_W-1:0]     pad2_y,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [2:0]         state,
    output logic               game_over,
    output logic               hit,
    output logic               upd
);

    localparam int SRV_W = $clog2(SERVE_TICKS + 1);
    localparam int DIV_W = $clog2(BALL_DIV + 1);

    localparam logic [X_W-1:0]     X_C      = X_W'(SCR_W / 2);
    localparam logic [Y_W-1:0]     Y_C      = Y_W'(SCR_H / 2);
    localparam logic [X_W-1:0]     X_MAX    = X_W'(SCR_W - 1);
    localparam logic [Y_W-1:0]     Y_MAX    = Y_W'(SCR_H - 1);
    localparam logic [X_W-1:0]     X_HIT_L  = X_W'(P1_X + 1);
    localparam logic [X_W-1:0]     X_HIT_R  = X_W'(P2_X - 1);
    localparam logic [Y_W:0]       PAD_SPAN = (Y_W+1)'(PAD_H - 1);
    localparam logic [SRV_W-1:0]   SRV_LAST = SRV_W'(SERVE_TICKS - 1);
    localparam logic [DIV_W-1:0]   DIV_INIT = DIV_W'(BALL_DIV);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    state_t             r_state;
    logic [X_W-1:0]     r_bx;
    logic [Y_W-1:0]     r_by;
    logic               r_dx, r_dy, r_serve_dy;
    logic [SCORE_W-1:0] r_s1, r_s2;
    logic               r_p1_scored;
    logic [SRV_W-1:0]   r_srv_cnt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_over, r_hit, r_upd;

    logic               w_pad_en, w_pad1_mov, w_pad2_mov;
    logic [Y_W-1:0]     w_pad1, w_pad2;
    logic [DIV_W-1:0]   w_div;
    logic               w_step, w_row1, w_row2;
    logic               w_dx_nxt, w_dy_nxt, w_hit_nxt, w_miss, w_p1_scores;
    logic [X_W-1:0]     w_bx_nxt;
    logic [Y_W-1:0]     w_by_nxt;
    logic [SCORE_W-1:0] w_s1_inc, w_s2_inc;

    assign w_pad_en = tick && (r_state == S_SERVE || r_state == S_PLAY);

    pong_paddle #(.Y_W(Y_W), .SCR_H(SCR_H), .PAD_H(PAD_H), .PAD_STEP(PAD_STEP)) u_pad1 (
        .clk(clk), .resetn(resetn), .i_en(w_pad_en), .i_up(p1_up), .i_down(p1_down),
        .o_y(w_pad1), .o_moving(w_pad1_mov)
    );

    pong_paddle #(.Y_W(Y_W), .SCR_H(SCR_H), .PAD_H(PAD_H), .PAD_STEP(PAD_STEP)) u_pad2 (
        .clk(clk), .resetn(resetn), .i_en(w_pad_en), .i_up(p2_up), .i_down(p2_down),
        .o_y(w_pad2), .o_moving(w_pad2_mov)
    );

    // Row tests read the paddle registers, i.e. positions before this tick's move.
    assign w_row1 = ({1'b0, r_by} >= {1'b0, w_pad1}) && ({1'b0, r_by} <= {1'b0, w_pad1} + PAD_SPAN);
    assign w_row2 = ({1'b0, r_by} >= {1'b0, w_pad2}) && ({1'b0, r_by} <= {1'b0, w_pad2} + PAD_SPAN);
    assign w_step = tick && (r_state == S_PLAY) && (r_div_cnt >= w_div - 1'b1);

    always_comb begin
        w_dx_nxt    = r_dx;
        w_dy_nxt    = r_dy;
        w_hit_nxt   = 1'b0;
        w_miss      = 1'b0;
        w_p1_scores = 1'b0;
        if (r_dy == DIR_NEG && r_by == '0) begin
            w_dy_nxt = DIR_POS;
        end else if (r_dy == DIR_POS && r_by == Y_MAX) begin
            w_dy_nxt = DIR_NEG;
        end
        if (r_dx == DIR_NEG) begin
            if (r_bx == '0) begin
                w_miss = 1'b1;
            end else if (r_bx == X_HIT_L && w_row1) begin
                w_dx_nxt  = DIR_POS;
                w_hit_nxt = 1'b1;
            end
        end else begin
            if (r_bx == X_MAX) begin
                w_miss      = 1'b1;
                w_p1_scores = 1'b1;
            end else if (r_bx == X_HIT_R && w_row2) begin
                w_dx_nxt  = DIR_NEG;
                w_hit_nxt = 1'b1;
            end
        end
        w_bx_nxt = (w_dx_nxt == DIR_POS) ? r_bx + 1'b1 : r_bx - 1'b1;
        w_by_nxt = (w_dy_nxt == DIR_POS) ? r_by + 1'b1 : r_by - 1'b1;
    end

`ifdef PONG_SPEEDUP_EN
    logic [1:0]       r_hits;
    logic [DIV_W-1:0] r_div;
    logic             w_serve_entry;

    assign w_serve_entry = (r_state == S_IDLE && go) || (r_state == S_POINT);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hits <= '0;
            r_div  <= DIV_INIT;
        end else if (w_serve_entry) begin
            r_hits <= '0;
            r_div  <= DIV_INIT;
        end else if (w_step && w_hit_nxt) begin
            r_hits <= r_hits + 1'b1;
            if (r_hits == 2'd3 && r_div > DIV_W'(1)) r_div <= r_div - 1'b1;
        end
    end

    assign w_div = r_div;
`else
    assign w_div = DIV_INIT;
`endif

    assign w_s1_inc = r_s1 + 1'b1;
    assign w_s2_inc = r_s2 + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_bx        <= X_C;
            r_by        <= Y_C;
            r_dx        <= DIR_POS;
            r_dy        <= DIR_POS;
            r_serve_dy  <= DIR_POS;
            r_s1        <= '0;
            r_s2        <= '0;
            r_p1_scored <= 1'b0;
            r_srv_cnt   <= '0;
            r_div_cnt   <= '0;
            r_over      <= 1'b0;
            r_hit       <= 1'b0;
            r_upd       <= 1'b0;
        end else begin
            r_hit <= 1'b0;
            r_upd <= w_pad1_mov | w_pad2_mov;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_state   <= S_SERVE;
                        r_s1      <= '0;
                        r_s2      <= '0;
                        r_srv_cnt <= '0;
                    end
                end
                S_SERVE: begin
                    if (tick) begin
                        if (r_srv_cnt == SRV_LAST) begin
                            r_state   <= S_PLAY;
                            r_div_cnt <= '0;
                        end else begin
                            r_srv_cnt <= r_srv_cnt + 1'b1;
                        end
                    end
                end
                S_PLAY: begin
                    if (tick) begin
                        r_div_cnt <= w_step ? '0 : r_div_cnt + 1'b1;
                        if (w_step && w_miss) begin
                            r_state     <= S_POINT;
                            r_p1_scored <= w_p1_scores;
                        end else if (w_step) begin
                            r_bx  <= w_bx_nxt;
                            r_by  <= w_by_nxt;
                            r_dx  <= w_dx_nxt;
                            r_dy  <= w_dy_nxt;
                            r_hit <= w_hit_nxt;
                            r_upd <= 1'b1;
                        end
                    end
                end
                S_POINT: begin
                    // The ball re-serves toward the player who conceded.
                    r_bx       <= X_C;
                    r_by       <= Y_C;
                    r_dx       <= r_p1_scored ? DIR_POS : DIR_NEG;
                    r_dy       <= ~r_serve_dy;
                    r_serve_dy <= ~r_serve_dy;
                    r_srv_cnt  <= '0;
                    r_upd      <= 1'b1;
                    if (r_p1_scored) r_s1 <= w_s1_inc;
                    else             r_s2 <= w_s2_inc;
                    if ((r_p1_scored ? w_s1_inc : w_s2_inc) == WIN) begin
                        r_state <= S_OVER;
                        r_over  <= 1'b1;
                    end else begin
                        r_state <= S_SERVE;
                    end
                end
                S_OVER: begin
                    if (go) begin
                        r_state <= S_IDLE;
                        r_s1    <= '0;
                        r_s2    <= '0;
                        r_over  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ball_x    = r_bx;
    assign ball_y    = r_by;
    assign pad1_y    = w_pad1;
    assign pad2_y    = w_pad2;
    assign score1    = r_s1;
    assign score2    = r_s2;
    assign state     = r_state;
    assign game_over = r_over;
    assign hit       = r_hit;
    assign upd       = r_upd;

endmodule

// File: doc/pong_core.md
Name: pong_core

Overview:
- Parametrised game engine for the VGA pong design. It replaces ad-hoc ball/paddle/score logic with one configurable block.
- Owns ball position and direction, both paddle positions, both scores, serve timing and game-over detection.
- Advances one step per tick pulse, supplied by the existing rate divider.
- Sits between player inputs (switches, debounced go pulse) and the object renderer that plots to the VGA adapter.

Parameters:
- X_W, 8, width of x coordinates
- Y_W, 7, width of y coordinates
- SCR_W, 160, screen width in pixels
- SCR_H, 120, screen height in pixels
- PAD_H, 12, paddle height in pixels
- PAD_STEP, 1, paddle pixels moved per tick
- P1_X, 2, left paddle column
- P2_X, 157, right paddle column
- SCORE_W, 4, score counter width
- WIN_SCORE, 9, score that ends the game (must be < 2^SCORE_W)
- SERVE_TICKS, 30, ticks the ball rests at centre before play
- BALL_DIV, 4, ticks per ball step (>=1)

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- tick  in  1  one-cycle step enable from the rate divider
- go  in  1  one-cycle start/restart pulse
- p1_up, p1_down, p2_up, p2_down  in  1 each  paddle controls (level)
- ball_x  out  X_W  ball column
- ball_y  out  Y_W  ball row
- pad1_y, pad2_y  out  Y_W  paddle top rows
- score1, score2  out  SCORE_W  player scores
- state  out  3  FSM state, for LEDs
- game_over  out  1  high while in OVER
- hit  out  1  one-cycle pulse on a paddle reflection
- upd  out  1  one-cycle pulse when positions changed; the renderer redraws

Behaviour:
- Reset (async, resetn=0) sets the following, with all outputs registered:
  - state=IDLE
  - ball=(SCR_W/2, SCR_H/2)
  - pads=(SCR_H-PAD_H)/2
  - scores=0
  - dx=+1, dy=+1
  - hit=upd=game_over=0
  - internal tick and divide counters=0
- FSM transitions:
  - IDLE: go -> SERVE (scores cleared). Ticks are ignored. go takes priority over a coincident tick.
  - SERVE: ball is held at centre; the serve counter counts ticks. After SERVE_TICKS ticks -> PLAY.
  - PLAY: ball steps every BALL_DIV ticks. On a miss -> POINT.
  - POINT: lasts one clk.
    - The scorer's score increments.
    - If the new score == WIN_SCORE -> OVER, else -> SERVE.
    - Ball re-centres; dx points toward the player who conceded; dy toggles relative to the previous serve.
  - OVER: positions frozen, game_over=1. go -> IDLE (scores cleared).
- Paddles (SERVE and PLAY only, on tick):
  - up&!down: y -= PAD_STEP, clamped at 0.
  - down&!up: y += PAD_STEP, clamped at SCR_H-PAD_H.
  - Both pressed or neither: hold.
- Ball step (PLAY, divide counter reaching BALL_DIV-1; the counter then wraps to 0). Direction is resolved first, then position += (dx, dy).
  - Vertical: dy=-1 and y==0 -> dy=+1; dy=+1 and y==SCR_H-1 -> dy=-1.
  - Left paddle: dx=-1, x==P1_X+1, pad1_y <= y <= pad1_y+PAD_H-1 -> dx=+1, hit pulse.
  - Right paddle: dx=+1, x==P2_X-1, same row test with pad2 -> dx=-1, hit pulse.
  - Miss: dx=-1 and x==0 -> point to P2 (no move). dx=+1 and x==SCR_W-1 -> point to P1 (no move).
  - Corner case: vertical and paddle reflection in the same step both apply.
  - Paddle test uses pad positions before the same tick's paddle update.
- Timing:
  - upd=1 for the clk after any tick that changed a ball or paddle position, and in the clk after POINT.
  - Latency from tick to new outputs is 1 clk.
- Arithmetic: coordinates unsigned; no wrap is possible because clamps and reflections bound them.

Optional Feature:
- PONG_SPEEDUP_EN defined:
  - A 2-bit hit counter increments on each hit.
  - On wrap (every 4 hits) the effective divisor decrements by 1, minimum 1.
  - Divisor restores to BALL_DIV at each serve.
- Undefined: divisor is constant BALL_DIV; no hit counter logic.

Decomposition:
- pong_pkg holds:
  - state encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4
  - direction constants DIR_POS / DIR_NEG
- Sub-module pong_paddle (clamped up/down paddle register, parameters PAD_H, PAD_STEP, SCR_H) is instantiated twice.

Test Plan:
- Reset, then go, then 30 ticks -> state SERVE to PLAY; ball (80,60); pads 54; upd pulses only on paddle movement.
- Ball dy=-1 reaching y=0 -> next step y=1, dy=+1; same check at y=119.
- Ball approaching left paddle, pad1_y=54, ball y=60 at x=3 -> hit pulse, dx=+1, next x=4. Repeat with pad1_y=0 -> x reaches 0, score2=1, SERVE with dx=-1.
- p1_up held for 60 ticks from 54 -> pad1_y clamps at 0. Both buttons held -> no change.
- Force score1 to 8, then one P1 point -> score1=9, state OVER, game_over=1, ticks ignored. go -> IDLE, scores 0.
- Assert resetn=0 mid-PLAY between clk edges -> outputs reach reset values immediately. With PONG_SPEEDUP_EN and BALL_DIV=4, 4 hits -> ball steps every 3 ticks.
